// File: rtl/api_slave.sv
// Serial work-unit receiver with a response shift-out path, clocked from clk.
// Optional: define API_SLAVE_NONCE_INC_EN to present word 2 incremented by one.
`timescale 1ns/1ps
module api_slave #(
  parameter int WORK_LEN    = 23,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        mosi,
  input  logic        load,
  output logic        miso,
  output logic        word_vld,
  output logic [31:0] word_dat,
  output logic [4:0]  word_idx,
  output logic        work_done,
  output logic        ovf,
  input  logic        rsp_vld,
  input  logic [31:0] rsp_dat,
  output logic        rsp_rdy
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(WORK_LEN - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, load_sync, settle;
  logic                   sck_d;
  logic [31:0]            rx, tx;
  logic [4:0]             bit_cnt, word_cnt;
  logic                   armed, sel_ok;

  logic        sck_s, mosi_s, load_s, rise, fall, settled;
  logic [31:0] rx_next;

  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign load_s  = load_sync[SYNC_STAGES-1];
  assign settled = settle[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_d;
  assign fall    = ~sck_s & sck_d;
  assign rx_next = {rx[30:0], mosi_s};
  assign miso    = (state == IDLE) | tx[31];

  function automatic logic [31:0] present_word(input logic [31:0] w, input logic [4:0] idx);
`ifdef API_SLAVE_NONCE_INC_EN
    return (idx == 5'd2) ? w + 32'd1 : w;
`else
    return w;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sck_sync  <= '0;
      mosi_sync <= '0;
      load_sync <= '1;
      settle    <= '0;
      sck_d     <= 1'b0;
      rx        <= '0;
      tx        <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      armed     <= 1'b0;
      sel_ok    <= 1'b0;
      word_vld  <= 1'b0;
      word_dat  <= '0;
      word_idx  <= '0;
      work_done <= 1'b0;
      ovf       <= 1'b0;
      rsp_rdy   <= 1'b0;
    end else begin
      sck_sync[0]  <= sck;
      mosi_sync[0] <= mosi;
      load_sync[0] <= load;
      settle[0]    <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i]  <= sck_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        load_sync[i] <= load_sync[i-1];
        settle[i]    <= settle[i-1];
      end
      sck_d     <= sck_s;
      word_vld  <= 1'b0;
      work_done <= 1'b0;
      rsp_rdy   <= 1'b0;

      case (state)
        // A new window needs load seen high after reset, so a select held
        // low through reset cannot restart reception.
        IDLE: begin
          if (load_s && settled) begin
            sel_ok <= 1'b1;
          end else if (!load_s && sel_ok) begin
            state  <= RECV;
            sel_ok <= 1'b0;
            armed  <= 1'b1;
          end
        end
        RECV: begin
          if (load_s) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
            armed    <= 1'b0;
            sel_ok   <= 1'b1;
          end else if (rise) begin
            rx      <= rx_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              word_vld <= 1'b1;
              word_dat <= present_word(rx_next, word_cnt);
              word_idx <= word_cnt;
              word_cnt <= word_cnt + 5'd1;
              armed    <= 1'b1;
              if (word_cnt == LAST_IDX) begin
                work_done <= 1'b1;
                state     <= DONE;
              end
            end
          end else if (fall) begin
            tx <= {tx[30:0], 1'b1};
          end else if (armed && bit_cnt == 5'd0 && !sck_s) begin
            // Word boundary: the last fall of the previous word has shifted.
            armed <= 1'b0;
            if (rsp_vld) begin
              tx      <= rsp_dat;
              rsp_rdy <= 1'b1;
            end else begin
              tx <= '1;
            end
          end
        end
        DONE: begin
          if (load_s) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
            armed    <= 1'b0;
            sel_ok   <= 1'b1;
          end else if (rise) begin
            ovf <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_api_slave.sv
// Scoreboard bench for api_slave: expected words queued as they are sent.
`timescale 1ns/1ps
module tb_api_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        load = 1'b1;
  logic        miso;
  logic        word_vld;
  logic [31:0] word_dat;
  logic [4:0]  word_idx;
  logic        work_done;
  logic        ovf;
  logic        rsp_vld = 1'b0;
  logic [31:0] rsp_dat = '0;
  logic        rsp_rdy;

  int n_tests = 0;
  int n_fail  = 0;
  int vld_cnt = 0;
  int done_cnt = 0;
  int rdy_cnt = 0;

  logic [31:0] q_dat[$];
  logic [4:0]  q_idx[$];
  logic        q_done[$];

  api_slave dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .load(load), .miso(miso),
    .word_vld(word_vld), .word_dat(word_dat), .word_idx(word_idx),
    .work_done(work_done), .ovf(ovf), .rsp_vld(rsp_vld), .rsp_dat(rsp_dat),
    .rsp_rdy(rsp_rdy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (work_done) done_cnt++;
    if (rsp_rdy) rdy_cnt++;
    if (word_vld) begin
      vld_cnt++;
      n_tests++;
      if (q_dat.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected: got dat=%h idx=%0d done=%b, required no strobe",
                 word_dat, word_idx, work_done);
      end else begin
        logic [31:0] ed;
        logic [4:0]  ei;
        logic        edn;
        ed = q_dat.pop_front();
        ei = q_idx.pop_front();
        edn = q_done.pop_front();
        if (word_dat !== ed || word_idx !== ei || work_done !== edn) begin
          n_fail++;
          $display("FAIL word_check: got dat=%h idx=%0d done=%b, required dat=%h idx=%0d done=%b",
                   word_dat, word_idx, work_done, ed, ei, edn);
        end
      end
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] w, input logic [4:0] idx);
`ifdef API_SLAVE_NONCE_INC_EN
    return (idx == 5'd2) ? w + 32'd1 : w;
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic send_bit(input logic b, output logic m);
    mosi = b;
    sck = 1'b0;
    repeat (8) @(negedge clk);
    m = miso;
    sck = 1'b1;
    repeat (8) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic push, input logic [4:0] idx,
                           output logic [31:0] mword);
    logic m;
    if (push) begin
      q_dat.push_back(exp_word(w, idx));
      q_idx.push_back(idx);
      q_done.push_back(idx == 5'd22);
    end
    for (int i = 31; i >= 0; i--) begin
      send_bit(w[i], m);
      mword[i] = m;
    end
  endtask

  task automatic open_window();
    load = 1'b1;
    repeat (6) @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic close_window();
    repeat (4) @(negedge clk);
    load = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if (miso !== 1'b1 || word_vld !== 1'b0 || word_dat !== 32'd0 || word_idx !== 5'd0 ||
        work_done !== 1'b0 || ovf !== 1'b0 || rsp_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got miso=%b vld=%b dat=%h idx=%0d done=%b ovf=%b rdy=%b, required 1 0 0 0 0 0 0",
               tag, miso, word_vld, word_dat, word_idx, work_done, ovf, rsp_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset_values");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("after_release");
  endtask

  task automatic test_full_unit();
    logic [31:0] mw;
    int v0, d0;
    v0 = vld_cnt; d0 = done_cnt;
    open_window();
    for (int k = 0; k < 23; k++) send_word(32'hA5A5_0000 + k, 1'b1, 5'(k), mw);
    close_window();
    check("full_vld_count", 32'(vld_cnt - v0), 32'd23);
    check("full_done_count", 32'(done_cnt - d0), 32'd1);
    check("full_queue_empty", 32'(q_dat.size()), 32'd0);
    check("full_ovf", {31'd0, ovf}, 32'd0);
    check("full_miso_idle", {31'd0, miso}, 32'd1);
  endtask

  task automatic test_response();
    logic [31:0] mw;
    int r0;
    r0 = rdy_cnt;
    rsp_dat = 32'h1234_5678;
    rsp_vld = 1'b1;
    open_window();
    rsp_vld = 1'b0;
    check("rsp_rdy_once", 32'(rdy_cnt - r0), 32'd1);
    send_word(32'h0BAD_F00D, 1'b1, 5'd0, mw);
    check("rsp_word0_miso", mw, 32'h1234_5678);
    send_word(32'h1357_9BDF, 1'b1, 5'd1, mw);
    check("rsp_word1_miso", mw, 32'hFFFF_FFFF);
    close_window();
    check("rsp_rdy_total", 32'(rdy_cnt - r0), 32'd1);
    check("rsp_queue_empty", 32'(q_dat.size()), 32'd0);
  endtask

  task automatic test_abort();
    logic [31:0] mw;
    logic m;
    int v0, d0;
    v0 = vld_cnt; d0 = done_cnt;
    open_window();
    send_word(32'hCAFE_0001, 1'b1, 5'd0, mw);
    for (int i = 0; i < 8; i++) send_bit(i[0], m);
    close_window();
    check("abort_vld_count", 32'(vld_cnt - v0), 32'd1);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    open_window();
    send_word(32'h7654_3210, 1'b1, 5'd0, mw);
    close_window();
    check("abort_restart_idx0", 32'(vld_cnt - v0), 32'd2);
    // Load rises on the same edge as the 32nd sck rise: no word expected.
    v0 = vld_cnt;
    open_window();
    for (int i = 0; i < 31; i++) send_bit(1'b1, m);
    mosi = 1'b0;
    repeat (8) @(negedge clk);
    sck = 1'b1;
    load = 1'b1;
    repeat (8) @(negedge clk);
    sck = 1'b0;
    repeat (8) @(negedge clk);
    check("load_priority_no_vld", 32'(vld_cnt - v0), 32'd0);
    check("abort_queue_empty", 32'(q_dat.size()), 32'd0);
  endtask

  task automatic test_overflow();
    logic [31:0] mw;
    logic m;
    int v0, d0;
    v0 = vld_cnt; d0 = done_cnt;
    open_window();
    for (int k = 0; k < 23; k++) send_word(32'h5000_0000 ^ (k * 32'h0101_0101), 1'b1, 5'(k), mw);
    check("ovf_before_extra", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, m);
    repeat (4) @(negedge clk);
    check("ovf_set", {31'd0, ovf}, 32'd1);
    close_window();
    check("ovf_sticky", {31'd0, ovf}, 32'd1);
    check("ovf_vld_count", 32'(vld_cnt - v0), 32'd23);
    check("ovf_done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic test_midreset();
    logic [31:0] mw;
    int v0, d0;
    do_reset();
    v0 = vld_cnt; d0 = done_cnt;
    open_window();
    for (int k = 0; k < 11; k++) send_word(32'h0F00_0000 + k, 1'b1, 5'(k), mw);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("midreset_values");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("midreset_release");
    send_word(32'hDEAD_BEEF, 1'b0, 5'd0, mw);
    send_word(32'hFEED_FACE, 1'b0, 5'd0, mw);
    repeat (8) @(negedge clk);
    check("midreset_no_strobe", 32'(vld_cnt - v0), 32'd11);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    check("midreset_miso_high", {31'd0, miso}, 32'd1);
    open_window();
    send_word(32'h2468_ACE0, 1'b1, 5'd0, mw);
    send_word(32'h1111_2222, 1'b1, 5'd1, mw);
    send_word(32'h3333_4444, 1'b1, 5'd2, mw);
    close_window();
    check("midreset_fresh_window", 32'(vld_cnt - v0), 32'd14);
    check("midreset_queue_empty", 32'(q_dat.size()), 32'd0);
  endtask

  initial begin
    test_reset();
    test_full_unit();
    test_response();
    test_abort();
    test_overflow();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
